// File: rtl/mdl_bubble_pkg.sv
// Shared definitions for the 005297 bubble access path: sequencer states,
// rotation-ring slot of the rotation tick and default page/timing constants.
package mdl_bubble_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPINUP = 3'd1,
        SEEK   = 3'd2,
        XFER   = 3'd3,
        SWAP   = 3'd4,
        STOP   = 3'd5
    } state_e;

    localparam int RTICK_SLOT      = 19;
    localparam int BITCNT_W        = 10;
    localparam int DEF_PAGE_BITS   = 584;
    localparam int DEF_SPINUP_CYC  = 4;
    localparam int DEF_TIMEOUT_CYC = 12000;
    localparam int DEF_CNT_W       = 14;

    // A rotation cycle ends on an enabled edge while the last ring slot is active.
    function automatic logic rtick_of(input logic [19:0] rot_n, input logic en);
        return en & ~rot_n[RTICK_SLOT];
    endfunction

endpackage

// File: rtl/mdl_rotcntr.sv
// Saturating rotation-cycle counter: clears on access accept, counts RTICKs,
// and flags the terminal count both one tick ahead and once reached.
module mdl_rotcntr #(
    parameter int CNT_W = 14,
    parameter int TERM  = 12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             term_next,
    output logic             term_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TERM_V  = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERM - 1);
    localparam logic [CNT_W-1:0] ONE_V   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // counter register; holds at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + ONE_V;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt       = cnt_r;
    assign term_next = inc && (cnt_r == TERM_M1);
    assign term_hit  = (cnt_r >= TERM_V);

endmodule

// File: rtl/mdl_accseq.sv
// Bubble access sequencer: walks one page access through spin-up, seek,
// transfer, swap (writes) and stop, driving the trigger-logic control levels.
module mdl_accseq
    import mdl_bubble_pkg::*;
#(
    parameter int SPINUP_CYC  = DEF_SPINUP_CYC,
    parameter int PAGE_BITS   = DEF_PAGE_BITS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                i_MCLK,
    input  logic                i_SYS_RST_n,
    input  logic                i_CLK2M_PCEN_n,
    input  logic [19:0]         i_ROT20_n,
    input  logic                i_REQ,
    input  logic                i_WR,
    input  logic                i_ABORT,
    input  logic                i_ACQ_START,
    input  logic                i_SWAP_START,
    input  logic                i_ACC_END,
    output logic                o_ACK,
    output logic                o_ROT_EN,
    output logic                o_UMODE_n,
    output logic                o_HALT,
    output logic                o_BDI_EN,
    output logic                o_SWAP_GATE,
    output logic                o_ACC_INVAL_n,
    output logic                o_CYCLECNTR_LSB,
    output logic [BITCNT_W-1:0] o_BITCNT,
    output logic                o_DONE,
    output logic                o_ERR
);

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(PAGE_BITS - 1);
    localparam logic [BITCNT_W-1:0] BIT_ONE  = {{(BITCNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    SPIN_M1  = CNT_W'(SPINUP_CYC - 1);

    state_e              state_r, state_s;
    logic                wr_r, wr_s;
    logic                ack_r, ack_s;
    logic                rot_en_r, rot_en_s;
    logic                umode_n_r, umode_n_s;
    logic                halt_r, halt_s;
    logic                bdi_en_r, bdi_en_s;
    logic                swap_gate_r, swap_gate_s;
    logic                inval_n_r, inval_n_s;
    logic [BITCNT_W-1:0] bitcnt_r, bitcnt_s;
    logic                done_r, done_s;
    logic                err_r, err_s;

    logic                en_s, rtick_s, cnt_clr_s, cnt_inc_s;
    logic                term_next_s, term_hit_s, spin_done_s, abort_s;
    logic [CNT_W-1:0]    cnt_s;
    logic                rot_unused_s;

    assign en_s         = ~i_CLK2M_PCEN_n;
    assign rtick_s      = rtick_of(i_ROT20_n, en_s);
    assign rot_unused_s = ^i_ROT20_n[18:0];

    assign cnt_clr_s = en_s && (state_r == IDLE) && i_REQ;
    assign cnt_inc_s = rtick_s && (state_r != IDLE);

    mdl_rotcntr #(
        .CNT_W (CNT_W),
        .TERM  (TIMEOUT_CYC)
    ) u_rotcntr (
        .clk       (i_MCLK),
        .rst_n     (i_SYS_RST_n),
        .clr       (cnt_clr_s),
        .inc       (cnt_inc_s),
        .cnt       (cnt_s),
        .term_next (term_next_s),
        .term_hit  (term_hit_s)
    );

    // Counter is zero at accept, so it counts spin-up RTICKs directly.
    assign spin_done_s = rtick_s && (cnt_s == SPIN_M1);
    assign abort_s     = en_s && (state_r != IDLE) && (state_r != STOP) &&
                         (i_ABORT || term_next_s || term_hit_s);

    // next-state and next-output decode; everything holds between enabled edges
    always_comb begin
        state_s     = state_r;
        wr_s        = wr_r;
        ack_s       = ack_r;
        rot_en_s    = rot_en_r;
        umode_n_s   = umode_n_r;
        halt_s      = halt_r;
        bdi_en_s    = bdi_en_r;
        swap_gate_s = swap_gate_r;
        inval_n_s   = inval_n_r;
        bitcnt_s    = bitcnt_r;
        done_s      = done_r;
        err_s       = err_r;
        if (en_s) begin
            ack_s  = 1'b0;
            done_s = 1'b0;
            if (abort_s) begin
                state_s     = STOP;
                halt_s      = 1'b0;
                bdi_en_s    = 1'b0;
                swap_gate_s = 1'b0;
                inval_n_s   = 1'b0;
                err_s       = 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (i_REQ) begin
                            wr_s      = i_WR;
                            ack_s     = 1'b1;
                            err_s     = 1'b0;
                            rot_en_s  = 1'b1;
                            umode_n_s = 1'b0;
                            halt_s    = 1'b1;
                            inval_n_s = 1'b1;
                            state_s   = SPINUP;
                        end else begin
                            state_s = IDLE;
                        end
                    end
                    SPINUP: begin
                        if (spin_done_s) begin
                            halt_s  = 1'b0;
                            state_s = SEEK;
                        end else begin
                            state_s = SPINUP;
                        end
                    end
                    SEEK: begin
                        if (i_ACQ_START) begin
                            bitcnt_s = {BITCNT_W{1'b0}};
                            bdi_en_s = ~wr_r;
                            state_s  = XFER;
                        end else begin
                            state_s = SEEK;
                        end
                    end
                    XFER: begin
                        if (rtick_s && (bitcnt_r == LAST_BIT)) begin
                            bdi_en_s = 1'b0;
                            state_s  = wr_r ? SWAP : STOP;
                        end else if (rtick_s) begin
                            bitcnt_s = bitcnt_r + BIT_ONE;
                        end else begin
                            state_s = XFER;
                        end
                    end
                    SWAP: begin
                        // gate covers one full rotation, closing on the RTICK after swap start
                        if (swap_gate_r && rtick_s) begin
                            swap_gate_s = 1'b0;
                            state_s     = STOP;
                        end else if (!swap_gate_r && i_SWAP_START) begin
                            swap_gate_s = 1'b1;
                        end else begin
                            state_s = SWAP;
                        end
                    end
                    STOP: begin
                        if (i_ACC_END) begin
                            rot_en_s  = 1'b0;
                            umode_n_s = 1'b1;
                            inval_n_s = 1'b1;
                            done_s    = 1'b1;
                            state_s   = IDLE;
                        end else begin
                            state_s = STOP;
                        end
                    end
                    default: begin
                        state_s     = IDLE;
                        rot_en_s    = 1'b0;
                        umode_n_s   = 1'b1;
                        halt_s      = 1'b0;
                        bdi_en_s    = 1'b0;
                        swap_gate_s = 1'b0;
                        inval_n_s   = 1'b1;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // state and output registers; reset is not qualified by the clock enable
    always_ff @(posedge i_MCLK) begin
        if (!i_SYS_RST_n) begin
            state_r     <= IDLE;
            wr_r        <= 1'b0;
            ack_r       <= 1'b0;
            rot_en_r    <= 1'b0;
            umode_n_r   <= 1'b1;
            halt_r      <= 1'b0;
            bdi_en_r    <= 1'b0;
            swap_gate_r <= 1'b0;
            inval_n_r   <= 1'b1;
            bitcnt_r    <= {BITCNT_W{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            wr_r        <= wr_s;
            ack_r       <= ack_s;
            rot_en_r    <= rot_en_s;
            umode_n_r   <= umode_n_s;
            halt_r      <= halt_s;
            bdi_en_r    <= bdi_en_s;
            swap_gate_r <= swap_gate_s;
            inval_n_r   <= inval_n_s;
            bitcnt_r    <= bitcnt_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign o_ACK           = ack_r;
    assign o_ROT_EN        = rot_en_r;
    assign o_UMODE_n       = umode_n_r;
    assign o_HALT          = halt_r;
    assign o_BDI_EN        = bdi_en_r;
    assign o_SWAP_GATE     = swap_gate_r;
    assign o_ACC_INVAL_n   = inval_n_r;
    assign o_CYCLECNTR_LSB = cnt_s[0];
    assign o_BITCNT        = bitcnt_r;
    assign o_DONE          = done_r;
    assign o_ERR           = err_r;

endmodule

// File: tb/tb_mdl_accseq.sv
// Bench for mdl_accseq: randomized clock-enable gaps and waits, expectations
// derived from RTICK counting against the access rules.
module tb_mdl_accseq;

    localparam int SPIN  = 4;
    localparam int PAGE  = 584;
    localparam int TMO_B = 50;
    localparam int SAT_B = 63;
    localparam logic [19:0] RST_VEC = {8'b0010_0010, 10'd0, 2'b00};

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic rst_n, pcen_n, req, req_b, wr, abort, acq, swp, acc_end;
    logic [19:0] rot_n;
    int slot, dis_run;
    int n_cmp, n_bad;

    logic ack, rot_en, umode_n, halt, bdi_en, swap_gate, inval_n, lsb, done, err;
    logic [9:0] bitcnt;
    logic ack_b, rot_en_b, umode_n_b, halt_b, bdi_en_b, swap_gate_b, inval_n_b, lsb_b, done_b, err_b;
    logic [9:0] bitcnt_b;

    assign rot_n = ~(20'd1 << slot);

    mdl_accseq #(.SPINUP_CYC(SPIN), .PAGE_BITS(PAGE), .TIMEOUT_CYC(12000), .CNT_W(14)) dut (
        .i_MCLK(mclk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot_n),
        .i_REQ(req), .i_WR(wr), .i_ABORT(abort), .i_ACQ_START(acq), .i_SWAP_START(swp),
        .i_ACC_END(acc_end), .o_ACK(ack), .o_ROT_EN(rot_en), .o_UMODE_n(umode_n),
        .o_HALT(halt), .o_BDI_EN(bdi_en), .o_SWAP_GATE(swap_gate), .o_ACC_INVAL_n(inval_n),
        .o_CYCLECNTR_LSB(lsb), .o_BITCNT(bitcnt), .o_DONE(done), .o_ERR(err));

    mdl_accseq #(.SPINUP_CYC(SPIN), .PAGE_BITS(PAGE), .TIMEOUT_CYC(TMO_B), .CNT_W(6)) dut_b (
        .i_MCLK(mclk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot_n),
        .i_REQ(req_b), .i_WR(wr), .i_ABORT(abort), .i_ACQ_START(acq), .i_SWAP_START(swp),
        .i_ACC_END(acc_end), .o_ACK(ack_b), .o_ROT_EN(rot_en_b), .o_UMODE_n(umode_n_b),
        .o_HALT(halt_b), .o_BDI_EN(bdi_en_b), .o_SWAP_GATE(swap_gate_b), .o_ACC_INVAL_n(inval_n_b),
        .o_CYCLECNTR_LSB(lsb_b), .o_BITCNT(bitcnt_b), .o_DONE(done_b), .o_ERR(err_b));

    // One MCLK cycle; reports whether that edge was enabled and an RTICK.
    task automatic tick(output bit en, output bit rt);
        en = (pcen_n == 1'b0);
        rt = en && (slot == 19);
        @(posedge mclk);
        #1;
        if (en) slot = (slot + 1) % 20;
        if (dis_run >= 3 || $urandom_range(0, 7) != 0) begin
            pcen_n = 1'b0; dis_run = 0;
        end else begin
            pcen_n = 1'b1; dis_run = dis_run + 1;
        end
    endtask

    task automatic etick(output bit rt);
        bit en;
        en = 1'b0; rt = 1'b0;
        while (!en) tick(en, rt);
    endtask

    task automatic wait_spinup(inout int rts);
        bit rt;
        for (int g = 0; g < 400 && halt === 1'b1; g++) begin etick(rt); if (rt) rts++; end
    endtask

    task automatic finish_access();
        bit rt;
        acc_end = 1'b1; etick(rt); acc_end = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        repeat (3) begin @(posedge mclk); #1; end
        obs = {ack, rot_en, umode_n, halt, bdi_en, swap_gate, inval_n, lsb, bitcnt, done, err};
        n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL reset_state: got %b want %b", obs, RST_VEC); end
        obs = {ack_b, rot_en_b, umode_n_b, halt_b, bdi_en_b, swap_gate_b, inval_n_b, lsb_b, bitcnt_b, done_b, err_b};
        n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL reset_state_b: got %b want %b", obs, RST_VEC); end
        rst_n = 1'b1; pcen_n = 1'b0;
    endtask

    task automatic test_read();
        bit rt; int rts, bits, nerr, exp_bc, wn;
        wr = 1'b0; req = 1'b1;
        etick(rt);
        req = 1'b0;
        n_cmp++; if ({ack, rot_en, umode_n, halt} !== 4'b1101) begin n_bad++; $display("FAIL read_accept: ack/rot_en/umode_n/halt=%b want 1101", {ack, rot_en, umode_n, halt}); end
        rts = 0;
        etick(rt); if (rt) rts++;
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL read_ack_pulse: ack=%b want 0", ack); end
        wait_spinup(rts);
        n_cmp++; if (rts != SPIN) begin n_bad++; $display("FAIL read_spinup: halt fell after %0d rticks want %0d", rts, SPIN); end
        wn = $urandom_range(0, 40);
        for (int i = 0; i < wn; i++) begin etick(rt); if (rt) rts++; end
        n_cmp++; if (bdi_en !== 1'b0) begin n_bad++; $display("FAIL read_seek_bdi: bdi_en=%b want 0", bdi_en); end
        acq = 1'b1; etick(rt); acq = 1'b0; if (rt) rts++;
        n_cmp++; if (bdi_en !== 1'b1 || bitcnt !== 10'd0) begin n_bad++; $display("FAIL read_xfer_entry: bdi_en=%b bitcnt=%0d want 1 0", bdi_en, bitcnt); end
        bits = 0; nerr = 0;
        for (int g = 0; g < 15000 && bdi_en === 1'b1; g++) begin
            etick(rt);
            if (rt) begin rts++; bits++; end
            exp_bc = (bits < PAGE) ? bits : PAGE - 1;
            n_cmp++;
            if (bitcnt !== 10'(exp_bc)) begin
                n_bad++; nerr++;
                if (nerr < 4) $display("FAIL read_bitcnt: got %0d want %0d", bitcnt, exp_bc);
            end
        end
        n_cmp++; if (bits != PAGE) begin n_bad++; $display("FAIL read_xfer_len: bdi_en high for %0d rticks want %0d", bits, PAGE); end
        n_cmp++; if (lsb !== 1'(rts % 2)) begin n_bad++; $display("FAIL read_cnt_lsb: got %b want %0d", lsb, rts % 2); end
        wn = $urandom_range(0, 20);
        for (int i = 0; i < wn; i++) etick(rt);
        n_cmp++; if (rot_en !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL read_stop_wait: rot_en=%b done=%b want 1 0", rot_en, done); end
        finish_access();
        n_cmp++; if ({done, rot_en, umode_n, err, inval_n} !== 5'b10101) begin n_bad++; $display("FAIL read_done: done/rot_en/umode_n/err/inval_n=%b want 10101", {done, rot_en, umode_n, err, inval_n}); end
        etick(rt);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL read_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_write();
        bit rt; int rts, bits, bdi_seen, exp_n, n, wn;
        bit last_rt;
        wr = 1'b1; req = 1'b1; etick(rt); req = 1'b0;
        rts = 0; bdi_seen = 0;
        wait_spinup(rts);
        swp = 1'b1; etick(rt); swp = 1'b0;
        n_cmp++; if (swap_gate !== 1'b0) begin n_bad++; $display("FAIL write_swap_in_seek: swap_gate=%b want 0", swap_gate); end
        acq = 1'b1; etick(rt); acq = 1'b0;
        if (bdi_en === 1'b1) bdi_seen++;
        bits = 0;
        for (int g = 0; g < 15000 && bits < PAGE; g++) begin
            etick(rt); if (rt) bits++;
            if (bdi_en === 1'b1) bdi_seen++;
        end
        n_cmp++; if (bitcnt !== 10'(PAGE - 1)) begin n_bad++; $display("FAIL write_last_bit: bitcnt=%0d want %0d", bitcnt, PAGE - 1); end
        wn = $urandom_range(0, 30);
        for (int i = 0; i < wn; i++) begin etick(rt); if (swap_gate === 1'b1) bdi_seen++; end
        n_cmp++; if (swap_gate !== 1'b0) begin n_bad++; $display("FAIL write_swap_idle: swap_gate=%b want 0", swap_gate); end
        swp = 1'b1; etick(rt); swp = 1'b0;
        n_cmp++; if (swap_gate !== 1'b1) begin n_bad++; $display("FAIL write_swap_open: swap_gate=%b want 1", swap_gate); end
        exp_n = 20 - slot; n = 0; last_rt = 1'b0;
        for (int g = 0; g < 200 && swap_gate === 1'b1; g++) begin etick(rt); n++; last_rt = rt; end
        n_cmp++; if (n != exp_n || !last_rt) begin n_bad++; $display("FAIL write_swap_len: gate for %0d enabled ticks (closed on rtick=%b) want %0d", n, last_rt, exp_n); end
        n_cmp++; if (bdi_seen != 0) begin n_bad++; $display("FAIL write_bdi: bdi_en/gate seen high %0d ticks want 0", bdi_seen); end
        finish_access();
        n_cmp++; if ({done, rot_en, err} !== 3'b100) begin n_bad++; $display("FAIL write_done: done/rot_en/err=%b want 100", {done, rot_en, err}); end
    endtask

    task automatic test_abort();
        bit rt; int rts, bits;
        wr = 1'b0; req = 1'b1; etick(rt); req = 1'b0;
        rts = 0; wait_spinup(rts);
        acq = 1'b1; etick(rt); acq = 1'b0;
        bits = 0;
        for (int g = 0; g < 5000 && bits < 100; g++) begin etick(rt); if (rt) bits++; end
        n_cmp++; if (bitcnt !== 10'd100) begin n_bad++; $display("FAIL abort_pos: bitcnt=%0d want 100", bitcnt); end
        abort = 1'b1; etick(rt); abort = 1'b0;
        n_cmp++; if ({bdi_en, inval_n, err, rot_en} !== 4'b0011) begin n_bad++; $display("FAIL abort_hit: bdi_en/inval_n/err/rot_en=%b want 0011", {bdi_en, inval_n, err, rot_en}); end
        for (int i = 0; i < 25; i++) etick(rt);
        n_cmp++; if (inval_n !== 1'b0 || bdi_en !== 1'b0) begin n_bad++; $display("FAIL abort_stop_hold: inval_n=%b bdi_en=%b want 0 0", inval_n, bdi_en); end
        finish_access();
        n_cmp++; if ({inval_n, done, err, rot_en} !== 4'b1110) begin n_bad++; $display("FAIL abort_end: inval_n/done/err/rot_en=%b want 1110", {inval_n, done, err, rot_en}); end
    endtask

    task automatic test_collision();
        bit rt, en; int rts, bits;
        wr = 1'b1; req = 1'b1; etick(rt); req = 1'b0;
        n_cmp++; if (err !== 1'b0 || ack !== 1'b1) begin n_bad++; $display("FAIL coll_err_clear: err=%b ack=%b want 0 1", err, ack); end
        rts = 0; wait_spinup(rts);
        for (int g = 0; g < 200 && !(slot == 19 && pcen_n == 1'b0); g++) tick(en, rt);
        acq = 1'b1; tick(en, rt); acq = 1'b0;
        n_cmp++; if (bitcnt !== 10'd0 || !rt) begin n_bad++; $display("FAIL coll_acq_rtick: bitcnt=%0d on rtick=%b want 0 1", bitcnt, rt); end
        bits = 0;
        for (int g = 0; g < 15000 && bits < PAGE - 1; g++) begin etick(rt); if (rt) bits++; end
        n_cmp++; if (bitcnt !== 10'(PAGE - 1)) begin n_bad++; $display("FAIL coll_last_bit: bitcnt=%0d want %0d", bitcnt, PAGE - 1); end
        for (int g = 0; g < 200 && !(slot == 19 && pcen_n == 1'b0); g++) tick(en, rt);
        abort = 1'b1; tick(en, rt); abort = 1'b0;
        n_cmp++; if ({err, inval_n} !== 2'b10) begin n_bad++; $display("FAIL coll_abort_final: err/inval_n=%b want 10", {err, inval_n}); end
        swp = 1'b1; etick(rt); swp = 1'b0;
        n_cmp++; if (swap_gate !== 1'b0) begin n_bad++; $display("FAIL coll_no_swap: swap_gate=%b want 0", swap_gate); end
        finish_access();
        n_cmp++; if (done !== 1'b1 || inval_n !== 1'b1) begin n_bad++; $display("FAIL coll_done: done=%b inval_n=%b want 1 1", done, inval_n); end
    endtask

    task automatic test_timeout();
        bit rt; int rts, sat, nerr;
        wr = 1'b0; req_b = 1'b1; etick(rt); req_b = 1'b0;
        n_cmp++; if (ack_b !== 1'b1) begin n_bad++; $display("FAIL tmo_accept: ack=%b want 1", ack_b); end
        rts = 0;
        for (int g = 0; g < 3000 && err_b !== 1'b1; g++) begin etick(rt); if (rt) rts++; end
        n_cmp++; if (rts != TMO_B || inval_n_b !== 1'b0) begin n_bad++; $display("FAIL tmo_fire: err after %0d rticks inval_n=%b want %0d 0", rts, inval_n_b, TMO_B); end
        nerr = 0;
        for (int g = 0; g < 3000 && rts < SAT_B + 8; g++) begin
            etick(rt);
            if (rt) begin
                rts++;
                sat = (rts < SAT_B) ? rts : SAT_B;
                n_cmp++;
                if (lsb_b !== 1'(sat % 2)) begin
                    n_bad++; nerr++;
                    if (nerr < 4) $display("FAIL tmo_sat_lsb: after %0d rticks lsb=%b want %0d", rts, lsb_b, sat % 2);
                end
            end
        end
        n_cmp++; if (rot_en_b !== 1'b1 || inval_n_b !== 1'b0) begin n_bad++; $display("FAIL tmo_hold: rot_en=%b inval_n=%b want 1 0", rot_en_b, inval_n_b); end
        finish_access();
        n_cmp++; if ({done_b, inval_n_b, rot_en_b, umode_n_b} !== 4'b1101) begin n_bad++; $display("FAIL tmo_end: done/inval_n/rot_en/umode_n=%b want 1101", {done_b, inval_n_b, rot_en_b, umode_n_b}); end
    endtask

    task automatic test_reset_mid();
        bit rt; int rts, wn;
        logic [19:0] obs;
        wr = 1'b0; req = 1'b1; etick(rt); req = 1'b0;
        rts = 0; wait_spinup(rts);
        acq = 1'b1; etick(rt); acq = 1'b0;
        wn = $urandom_range(20, 200);
        for (int i = 0; i < wn; i++) etick(rt);
        n_cmp++; if (bdi_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: bdi_en=%b want 1", bdi_en); end
        pcen_n = 1'b1; rst_n = 1'b0;
        @(posedge mclk); #1;
        obs = {ack, rot_en, umode_n, halt, bdi_en, swap_gate, inval_n, lsb, bitcnt, done, err};
        n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL rstmid_state: got %b want %b", obs, RST_VEC); end
        rst_n = 1'b1; pcen_n = 1'b0;
        for (int i = 0; i < 5; i++) etick(rt);
        n_cmp++; if (rot_en !== 1'b0 || halt !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: rot_en=%b halt=%b want 0 0", rot_en, halt); end
    endtask

    task automatic test_back_to_back();
        bit rt;
        wr = 1'b0; req = 1'b1; etick(rt);
        abort = 1'b1; etick(rt); abort = 1'b0;
        n_cmp++; if (ack !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL b2b_req_ignored: ack=%b err=%b want 0 1", ack, err); end
        finish_access();
        n_cmp++; if (done !== 1'b1 || ack !== 1'b0) begin n_bad++; $display("FAIL b2b_done: done=%b ack=%b want 1 0", done, ack); end
        etick(rt);
        n_cmp++; if ({ack, err, rot_en, done} !== 4'b1010) begin n_bad++; $display("FAIL b2b_restart: ack/err/rot_en/done=%b want 1010", {ack, err, rot_en, done}); end
        req = 1'b0;
        abort = 1'b1; etick(rt); abort = 1'b0;
        finish_access();
        n_cmp++; if (done !== 1'b1 || rot_en !== 1'b0) begin n_bad++; $display("FAIL b2b_final: done=%b rot_en=%b want 1 0", done, rot_en); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; slot = 0; dis_run = 0;
        rst_n = 1'b0; pcen_n = 1'b1;
        req = 1'b0; req_b = 1'b0; wr = 1'b0; abort = 1'b0;
        acq = 1'b0; swp = 1'b0; acc_end = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_abort();
        test_collision();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdl_accseq.md
Name: mdl_accseq

Overview:
- Bubble access sequencer for the 005297 bubble memory controller. It takes one page-access request from the host side and sequences the magnetic-field rotation through its phases: spin-up, page seek, data transfer, swap (write only) and stop.
- It produces the control levels that the trigger logic consumes: UMODE_n, HALT, BDI_EN and ACC_INVAL_n.
- It consumes the trigger pulses that the trigger logic produces: ACQ_START, SWAP_START and ACC_END.
- It sits between the host command register and the rotation/trigger datapath.

Parameters:
- SPINUP_CYC, 4: rotation cycles to wait after rotation enable before page compare is allowed.
- PAGE_BITS, 584: bubble bits transferred per page. Each rotation cycle transfers 1 bit.
- TIMEOUT_CYC, 12000: maximum rotation cycles from leaving IDLE until ACC_END. Exceeding it aborts the access.
- CNT_W, 14: width of the cycle counter. It must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- i_MCLK  in  1  master clock.
- i_SYS_RST_n  in  1  synchronous active-low reset. Sampled on every i_MCLK edge, not gated by clock enables.
- i_CLK2M_PCEN_n  in  1  active-low 2 MHz clock enable. All state advances only on i_MCLK edges where this is 0.
- i_ROT20_n  in  20  active-low one-hot rotation slot ring. A rotation cycle ends at the enabled edge where bit 19 is 0 (the "RTICK").
- i_REQ  in  1  access request level. Held by the host until o_ACK.
- i_WR  in  1  1 = write page, 0 = read page. Sampled together with i_REQ.
- i_ABORT  in  1  host abort level.
- i_ACQ_START  in  1  acquisition start from the trigger logic.
- i_SWAP_START  in  1  swap start from the trigger logic.
- i_ACC_END  in  1  access end from the trigger logic.
- o_ACK  out  1  one-enable-tick pulse when a request is accepted.
- o_ROT_EN  out  1  field rotation enable.
- o_UMODE_n  out  1  0 = user-mode timing active.
- o_HALT  out  1  freezes the trigger comparators.
- o_BDI_EN  out  1  bubble data interface enable (read transfer).
- o_SWAP_GATE  out  1  swap gate drive (write).
- o_ACC_INVAL_n  out  1  0 = access invalid (abort/timeout).
- o_CYCLECNTR_LSB  out  1  bit 0 of the rotation cycle counter.
- o_BITCNT  out  10  current bit index within the page.
- o_DONE  out  1  one-enable-tick pulse at completion.
- o_ERR  out  1  sticky error flag. Cleared on the next accept.

Behaviour:
- Reset values (state IDLE):
  - 0: o_ACK, o_ROT_EN, o_HALT, o_BDI_EN, o_SWAP_GATE, o_DONE, o_ERR, o_BITCNT, cycle counter.
  - 1: o_UMODE_n, o_ACC_INVAL_n.
- Reset mid-operation forces IDLE on the next i_MCLK edge. It takes precedence over all events.
- All transitions below occur only on enabled edges, where i_CLK2M_PCEN_n = 0.
- IDLE:
  - If i_REQ=1: latch i_WR, pulse o_ACK, clear o_ERR, clear the cycle counter, set o_ROT_EN=1 and o_UMODE_n=0, then go to SPINUP.
- SPINUP:
  - Count RTICKs. After SPINUP_CYC RTICKs, go to SEEK.
  - o_HALT=1 for the whole state.
- SEEK:
  - o_HALT=0.
  - On i_ACQ_START=1: clear o_BITCNT. For a read, set o_BDI_EN=1. Go to XFER.
- XFER:
  - Each RTICK increments o_BITCNT.
  - When o_BITCNT = PAGE_BITS-1 and an RTICK occurs: clear o_BDI_EN.
    - Write: go to SWAP.
    - Read: go to STOP.
  - Latency is exactly PAGE_BITS RTICKs from XFER entry.
- SWAP (write only):
  - On i_SWAP_START=1: o_SWAP_GATE=1 for exactly one rotation cycle, up to and including the next RTICK. Then go to STOP.
- STOP:
  - On i_ACC_END=1: o_ROT_EN=0, o_UMODE_n=1, o_DONE pulse, go to IDLE.
- Cycle counter:
  - CNT_W bits. Increments on every RTICK outside IDLE. Saturates at all-ones and never wraps.
  - o_CYCLECNTR_LSB = counter[0].
- Timeout:
  - When the counter reaches TIMEOUT_CYC in any non-IDLE state, the access aborts.
- Abort (i_ABORT=1 or timeout, in any non-IDLE state):
  - o_ACC_INVAL_n=0, o_BDI_EN=0, o_SWAP_GATE=0, o_ERR=1, go to STOP.
  - In STOP, o_ACC_INVAL_n stays 0 until i_ACC_END, then returns to 1 with the o_DONE pulse.
  - Abort in STOP is ignored.
- Simultaneous events:
  - Abort beats i_ACQ_START, i_SWAP_START and the final-bit RTICK.
  - An i_ACQ_START coinciding with an RTICK starts XFER with o_BITCNT=0. That RTICK is not counted as a bit.
- Ignored inputs:
  - Trigger pulses are ignored outside their own state.
  - i_REQ is ignored outside IDLE.
  - If i_REQ is still high after o_DONE, a new access starts on the next enabled edge.

Decomposition:
- Shared package mdl_bubble_pkg:
  - state enum: IDLE, SPINUP, SEEK, XFER, SWAP, STOP.
  - RTICK slot index constant: 19.
  - Default PAGE_BITS, SPINUP_CYC and TIMEOUT_CYC.
- One natural sub-module, mdl_rotcntr: the saturating RTICK cycle counter with clear, enable and terminal-compare outputs.

Test Plan:
- Read: REQ=1, WR=0, SPINUP_CYC=4 → ACK 1 tick; ROT_EN=1. After 4 RTICKs, HALT falls. Pulse ACQ_START → BDI_EN=1 for exactly 584 RTICKs with BITCNT reaching 583. ACC_END → DONE pulse, ROT_EN=0, ERR=0.
- Write: WR=1; after XFER, pulse SWAP_START → SWAP_GATE high for exactly 1 rotation cycle (20 enabled ticks worst case). BDI_EN never asserts. DONE follows ACC_END.
- Abort: assert ABORT at BITCNT=100 during read → same tick BDI_EN=0, ACC_INVAL_n=0, ERR=1, state STOP. ACC_END → ACC_INVAL_n=1, DONE pulse.
- Timeout: TIMEOUT_CYC=50, never pulse ACQ_START → at counter=50, ERR=1 and ACC_INVAL_n=0. Counter saturates if ACC_END is withheld. ACC_END then returns the block to IDLE.
- Reset: drop SYS_RST_n mid-XFER with CLK2M_PCEN_n=1 → all outputs at reset values on the next MCLK edge.
- Collision: ACQ_START coincident with RTICK → BITCNT=0 at XFER entry. ABORT coincident with the final-bit RTICK → ERR=1, no transition to SWAP.
